// File: rtl/thor2022_tlb_walker_if.sv
// rtl/thor2022_tlb_walker_if.sv - 128-bit read bus between the TLB walker and memory
//
// cyc : read request, held until ack or watchdog expiry
// adr : byte address of the 16-byte table entry, stable while cyc=1
// ack : read acknowledge, dat valid in the same cycle
// dat : 128-bit read data
interface thor2022_tlb_walker_if;
    logic         cyc;
    logic [31:0]  adr;
    logic         ack;
    logic [127:0] dat;

    modport master (output cyc, output adr, input ack, input dat);
    modport slave  (input cyc, input adr, output ack, output dat);
endinterface

// File: rtl/thor2022_tlb_walker.sv
// rtl/thor2022_tlb_walker.sv - two-level page-table walker that installs TLB entries on a miss
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   en_i                   walker enable (misses ignored when low)
//   ptbr_i, asid_i         page-table base (16-byte aligned), current ASID
//   tlbmiss_i/_adr_i       miss flag and missing virtual address
//   tlb_rdy_i              TLB can accept a software write
//   m                      128-bit read master bus
//   wrtlb_o/tlbadr_o/tlbdat_o  TLB write port, one-cycle strobe
//   busy_o, done_o         walk in progress, install-complete pulse
//   fault_o/_cause_o/_adr_o    fault pulse, cause (1 PDE, 2 PTE, 3 timeout), va
//
// tlbdat_o layout (128 bits):
//   [127:100] 0  [99:84] access_count  [83] v  [82] m  [81] g  [80:78] rwx
//   [77:62] vpn  [61:54] asid  [53:22] key  [21:19] me  [18:16] mb  [15:0] ppn
module thor2022_tlb_walker #(
    parameter logic [2:0]  WAY    = 3'd0,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned TMO    = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [31:0]                  ptbr_i,
    input  logic [7:0]                   asid_i,
    input  logic                         tlbmiss_i,
    input  logic [31:0]                  tlbmiss_adr_i,
    input  logic                         tlb_rdy_i,
    thor2022_tlb_walker_if.master        m,
    output logic                         wrtlb_o,
    output logic [15:0]                  tlbadr_o,
    output logic [127:0]                 tlbdat_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         fault_o,
    output logic [1:0]                   fault_cause_o,
    output logic [31:0]                  fault_adr_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_PDE   = 3'd1;
    localparam logic [2:0] S_RD_PTE   = 3'd2;
    localparam logic [2:0] S_WAIT_RDY = 3'd3;
    localparam logic [2:0] S_WR_TLB   = 3'd4;
    localparam logic [2:0] S_SETTLE   = 3'd5;
    localparam logic [2:0] S_FAULT    = 3'd6;

    // Last count values; the read times out on the cycle the watchdog would reach TMO.
    localparam logic [7:0] WDOG_LAST   = 8'(TMO - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [2:0]   state_q;
    logic [31:0]  va_q;
    logic [19:0]  base_q;
    logic [7:0]   wdog_q;
    logic [7:0]   settle_q;
    logic         cyc_q;
    logic [31:0]  adr_q;
    logic         wrtlb_q;
    logic [15:0]  tlbadr_q;
    logic [127:0] tlbdat_q;
    logic         done_q;
    logic         fault_q;
    logic [1:0]   cause_q;
    logic [31:0]  fault_adr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            va_q        <= '0;
            base_q      <= '0;
            wdog_q      <= '0;
            settle_q    <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            wrtlb_q     <= 1'b0;
            tlbadr_q    <= '0;
            tlbdat_q    <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= '0;
            fault_adr_q <= '0;
        end else begin
            wrtlb_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en_i && tlbmiss_i) begin
                        va_q    <= tlbmiss_adr_i;
                        cyc_q   <= 1'b1;
                        adr_q   <= ptbr_i + {22'h0, tlbmiss_adr_i[31:26], 4'h0};
                        wdog_q  <= '0;
                        state_q <= S_RD_PDE;
                    end
                end
                S_RD_PDE: begin
                    // An ack in the expiry cycle still wins over the watchdog.
                    if (m.ack) begin
                        cyc_q <= 1'b0;
                        if (!m.dat[0]) begin
                            fault_q     <= 1'b1;
                            cause_q     <= 2'd1;
                            fault_adr_q <= va_q;
                            state_q     <= S_FAULT;
                        end else begin
                            base_q  <= m.dat[31:12];
                            wdog_q  <= '0;
                            state_q <= S_RD_PTE;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        cyc_q       <= 1'b0;
                        fault_q     <= 1'b1;
                        cause_q     <= 2'd3;
                        fault_adr_q <= va_q;
                        state_q     <= S_FAULT;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                S_RD_PTE: begin
                    // First cycle here is the mandatory bus gap; the PTE read is issued after it.
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        adr_q <= {base_q, 12'h000} + {18'h0, va_q[25:16], 4'h0};
                    end else if (m.ack) begin
                        cyc_q <= 1'b0;
                        if (!m.dat[0]) begin
                            fault_q     <= 1'b1;
                            cause_q     <= 2'd2;
                            fault_adr_q <= va_q;
                            state_q     <= S_FAULT;
                        end else begin
                            tlbdat_q <= {28'h0, 16'h0, 1'b1, 1'b0, m.dat[4], m.dat[3:1],
                                         va_q[31:16], m.dat[15:8], m.dat[95:64],
                                         m.dat[38:36], m.dat[34:32], m.dat[31:16]};
                            tlbadr_q <= {va_q[25:16], 2'b00, 1'b0, WAY};
                            state_q  <= S_WAIT_RDY;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        cyc_q       <= 1'b0;
                        fault_q     <= 1'b1;
                        cause_q     <= 2'd3;
                        fault_adr_q <= va_q;
                        state_q     <= S_FAULT;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                S_WAIT_RDY: begin
                    if (tlb_rdy_i) begin
                        wrtlb_q <= 1'b1;
                        state_q <= S_WR_TLB;
                    end
                end
                S_WR_TLB: begin
                    settle_q <= '0;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                S_FAULT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m.cyc         = cyc_q;
    assign m.adr         = adr_q;
    assign wrtlb_o       = wrtlb_q;
    assign tlbadr_o      = tlbadr_q;
    assign tlbdat_o      = tlbdat_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_adr_o   = fault_adr_q;

    // Entry bits the TLB format has no room for, and the ASID (entries carry the PTE's ASID).
    logic unused_bits;
    assign unused_bits = ^{asid_i, m.dat[127:96], m.dat[63:39], m.dat[35], m.dat[7:5]};

endmodule
